// File: rtl/place_bmp_if.sv
// rtl/place_bmp_if.sv - command, ROM and video-write bundle for place_bmp_param
// Signals:
//   cmd_valid/cmd_ready    command handshake; cmd_op/cmd_img/cmd_chr/cmd_x/cmd_y payload
//   rom_sel/rom_addr       ROM select and address (select N_IMG is the font ROM)
//   rom_data               ROM read data, one cycle after the address
//   waddr/wdata/we         linear video write port
//   busy/done              engine activity and single-cycle completion pulse
// Modports: slave = placer engine, master = command source, ROMs and video memory.
interface place_bmp_if #(
    parameter int N_IMG = 4,
    parameter int PIX_W = 6
) ();
    localparam int IMG_W = $clog2(N_IMG + 1);

    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [IMG_W-1:0] cmd_img;
    logic [5:0]       cmd_chr;
    logic [9:0]       cmd_x;
    logic [8:0]       cmd_y;
    logic [IMG_W-1:0] rom_sel;
    logic [15:0]      rom_addr;
    logic [PIX_W-1:0] rom_data;
    logic [18:0]      waddr;
    logic [PIX_W-1:0] wdata;
    logic             we;
    logic             busy;
    logic             done;

    modport slave (
        input  cmd_valid, cmd_op, cmd_img, cmd_chr, cmd_x, cmd_y, rom_data,
        output cmd_ready, rom_sel, rom_addr, waddr, wdata, we, busy, done
    );

    modport master (
        output cmd_valid, cmd_op, cmd_img, cmd_chr, cmd_x, cmd_y, rom_data,
        input  cmd_ready, rom_sel, rom_addr, waddr, wdata, we, busy, done
    );
endinterface

// File: rtl/place_bmp_param.sv
// rtl/place_bmp_param.sv - places bitmap images and font glyphs into a linear frame buffer
// Ports:
//   clk     clock
//   rst_n   asynchronous active-low reset; forces a full screen clear afterwards
//   bus     place_bmp_if.slave: command handshake, ROM read port, video write port, busy/done
// Operations: 0 add image, 1 remove image (writes 0 under the image's opaque pixels),
//   2 add glyph from the font ROM, 3 clear screen.
// Build option: define PLACE_CLIP_EN to suppress writes for pixels with x>=H_RES or y>=V_RES;
//   without it off-screen pixels wrap linearly through the 19-bit address space.
module place_bmp_param #(
    parameter int               H_RES       = 640,
    parameter int               V_RES       = 480,
    parameter int               PIX_W       = 6,
    parameter int               N_IMG       = 4,
    parameter logic [PIX_W-1:0] TRANSP      = 6'h24,
    parameter int               GLYPH_W     = 13,
    parameter int               GLYPH_H     = 16,
    parameter int               FONT_STRIDE = 544
) (
    input  logic         clk,
    input  logic         rst_n,
    place_bmp_if.slave   bus
);
    localparam int IMG_W = $clog2(N_IMG + 1);
    localparam int DIM_W = 12;
    localparam int CRD_W = 13;

    typedef enum logic [2:0] {CLR, IDLE, HDR, WRT, GLY, FIN} state_t;

    state_t           state_q;
    logic [18:0]      clr_ptr_q;
    logic [18:0]      wptr_q;
    logic [18:0]      waddr_q;
    logic [PIX_W-1:0] wdata_q;
    logic             we_q;
    logic             done_q;
    logic [IMG_W-1:0] rom_sel_q;
    logic [15:0]      rom_addr_q;
    logic [15:0]      row_base_q;
    logic [7:0]       icol_q;
    logic [2:0]       hcnt_q;
    logic             prime_q;
    logic             rm_q;
    logic [PIX_W-1:0] xhi_q;
    logic [PIX_W-1:0] yhi_q;
    logic [DIM_W-1:0] w_q;
    logic [DIM_W-1:0] h_q;
    logic [DIM_W-1:0] col_q;
    logic [DIM_W-1:0] row_q;
    logic [9:0]       x0_q;
    logic [CRD_W-1:0] cur_x_q;
    logic [CRD_W-1:0] cur_y_q;

    logic [15:0]      rom_addr_d;
    logic [15:0]      row_base_d;
    logic [7:0]       icol_d;
    logic [18:0]      base_d;
    logic [18:0]      wptr_row_d;
    logic [15:0]      font_base_d;
    logic [DIM_W-1:0] h_hdr_d;
    logic             onscreen_d;
    logic             pix_we_d;
    logic             pix_en_d;

    function automatic logic [DIM_W-1:0] dim(input logic [PIX_W-1:0] hi, input logic [PIX_W-1:0] lo);
        return (DIM_W'(hi) << 6) + DIM_W'(lo);
    endfunction

    // ROM address issue runs two cycles ahead of the pixel being written.
    // Images are read contiguously; glyphs jump by FONT_STRIDE at each glyph row end.
    always_comb begin
        rom_addr_d = rom_addr_q + 16'd1;
        row_base_d = row_base_q;
        icol_d     = icol_q + 8'd1;
        if (state_q == GLY && icol_q == 8'(GLYPH_W - 1)) begin
            icol_d     = 8'd0;
            row_base_d = row_base_q + 16'(FONT_STRIDE);
            rom_addr_d = row_base_q + 16'(FONT_STRIDE);
        end
    end

    always_comb begin
        base_d      = 19'(bus.cmd_y) * 19'(H_RES) + 19'(bus.cmd_x);
        wptr_row_d  = wptr_q + 19'(H_RES) - 19'(w_q) + 19'd1;
        font_base_d = 16'(bus.cmd_chr) * 16'(GLYPH_W);
        h_hdr_d     = dim(yhi_q, bus.rom_data);
`ifdef PLACE_CLIP_EN
        onscreen_d  = (cur_x_q < CRD_W'(H_RES)) && (cur_y_q < CRD_W'(V_RES));
`else
        onscreen_d  = 1'b1;
`endif
        pix_we_d    = (bus.rom_data != TRANSP) && onscreen_d;
        // Glyph data lags its first address by one priming cycle.
        pix_en_d    = (state_q == WRT) || (state_q == GLY && !prime_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= CLR;
            clr_ptr_q  <= '0;
            wptr_q     <= '0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            done_q     <= 1'b0;
            rom_sel_q  <= '0;
            rom_addr_q <= '0;
            row_base_q <= '0;
            icol_q     <= '0;
            hcnt_q     <= '0;
            prime_q    <= 1'b0;
            rm_q       <= 1'b0;
            xhi_q      <= '0;
            yhi_q      <= '0;
            w_q        <= '0;
            h_q        <= '0;
            col_q      <= '0;
            row_q      <= '0;
            x0_q       <= '0;
            cur_x_q    <= '0;
            cur_y_q    <= '0;
        end else begin
            we_q   <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                CLR: begin
                    we_q      <= 1'b1;
                    wdata_q   <= '0;
                    waddr_q   <= clr_ptr_q;
                    clr_ptr_q <= clr_ptr_q + 19'd1;
                    if (clr_ptr_q == 19'(H_RES * V_RES - 1)) begin
                        state_q <= FIN;
                        done_q  <= 1'b1;
                    end
                end
                IDLE: begin
                    if (bus.cmd_valid) begin
                        rm_q    <= (bus.cmd_op == 2'd1);
                        x0_q    <= bus.cmd_x;
                        cur_x_q <= CRD_W'(bus.cmd_x);
                        cur_y_q <= CRD_W'(bus.cmd_y);
                        wptr_q  <= base_d;
                        col_q   <= '0;
                        row_q   <= '0;
                        case (bus.cmd_op)
                            2'd3: begin
                                clr_ptr_q <= '0;
                                state_q   <= CLR;
                            end
                            2'd2: begin
                                rom_sel_q  <= IMG_W'(N_IMG);
                                rom_addr_q <= font_base_d;
                                row_base_q <= font_base_d;
                                icol_q     <= '0;
                                prime_q    <= 1'b1;
                                w_q        <= DIM_W'(GLYPH_W);
                                h_q        <= DIM_W'(GLYPH_H);
                                state_q    <= GLY;
                            end
                            default: begin
                                if (bus.cmd_img >= IMG_W'(N_IMG)) begin
                                    state_q <= FIN;
                                    done_q  <= 1'b1;
                                end else begin
                                    rom_sel_q  <= bus.cmd_img;
                                    rom_addr_q <= '0;
                                    hcnt_q     <= '0;
                                    state_q    <= HDR;
                                end
                            end
                        endcase
                    end
                end
                HDR: begin
                    // Header word k arrives when hcnt_q == k+1.
                    rom_addr_q <= rom_addr_d;
                    hcnt_q     <= hcnt_q + 3'd1;
                    case (hcnt_q)
                        3'd1: xhi_q <= bus.rom_data;
                        3'd2: w_q   <= dim(xhi_q, bus.rom_data);
                        3'd3: yhi_q <= bus.rom_data;
                        3'd4: begin
                            h_q <= h_hdr_d;
                            if (w_q == '0 || h_hdr_d == '0) begin
                                state_q <= FIN;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= WRT;
                            end
                        end
                        default: ;
                    endcase
                end
                WRT: rom_addr_q <= rom_addr_d;
                GLY: begin
                    rom_addr_q <= rom_addr_d;
                    row_base_q <= row_base_d;
                    icol_q     <= icol_d;
                    prime_q    <= 1'b0;
                end
                FIN:     state_q <= IDLE;
                default: state_q <= CLR;
            endcase

            if (pix_en_d) begin
                we_q    <= pix_we_d;
                wdata_q <= rm_q ? '0 : bus.rom_data;
                waddr_q <= wptr_q;
                if (col_q == w_q - DIM_W'(1)) begin
                    col_q   <= '0;
                    row_q   <= row_q + DIM_W'(1);
                    cur_x_q <= CRD_W'(x0_q);
                    cur_y_q <= cur_y_q + CRD_W'(1);
                    wptr_q  <= wptr_row_d;
                    if (row_q == h_q - DIM_W'(1)) begin
                        state_q <= FIN;
                        done_q  <= 1'b1;
                    end
                end else begin
                    col_q   <= col_q + DIM_W'(1);
                    cur_x_q <= cur_x_q + CRD_W'(1);
                    wptr_q  <= wptr_q + 19'd1;
                end
            end
        end
    end

    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;
    assign bus.we        = we_q;
    assign bus.waddr     = waddr_q;
    assign bus.wdata     = wdata_q;
    assign bus.rom_sel   = rom_sel_q;
    assign bus.rom_addr  = rom_addr_q;
endmodule

// File: tb/tb_place_bmp_param.sv
// tb/tb_place_bmp_param.sv - directed self-checking bench for place_bmp_param
// Screen reduced to 640x16 so full clears stay short while row addressing keeps H_RES=640.
module tb_place_bmp_param;
    localparam int H  = 640;
    localparam int V  = 16;
    localparam int PW = 6;
    localparam int NI = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    place_bmp_if #(.N_IMG(NI), .PIX_W(PW)) bus ();

    place_bmp_param #(.H_RES(H), .V_RES(V), .PIX_W(PW), .N_IMG(NI)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [5:0] img_mem [NI][128];

    function automatic logic [5:0] font_pix(input logic [15:0] a);
        return (a[3:0] == 4'h0) ? 6'h24 : {2'b00, a[3:0]};
    endfunction

    always @(posedge clk)
        bus.rom_data <= (bus.rom_sel == 3'(NI)) ? font_pix(bus.rom_addr)
                                                : img_mem[bus.rom_sel[1:0]][bus.rom_addr[6:0]];

    int checks = 0;
    int failures = 0;
    int wa_q[$];
    int wd_q[$];
    int wc_q[$];
    int ra_q[$];
    int done_cyc;
    int rsel0;
    int exp_a[$];
    int exp_d[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic run_cmd(input int op, input int img, input int chr, input int x, input int y);
        int n;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'(op);
        bus.cmd_img   = 3'(img);
        bus.cmd_chr   = 6'(chr);
        bus.cmd_x     = 10'(x);
        bus.cmd_y     = 9'(y);
        n = 0;
        while (!bus.cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        wa_q.delete(); wd_q.delete(); wc_q.delete(); ra_q.delete();
        done_cyc = -1;
        rsel0 = int'(bus.rom_sel);
        for (int c = 0; c < 20000; c++) begin
            ra_q.push_back(int'(bus.rom_addr));
            if (bus.we) begin
                wa_q.push_back(int'(bus.waddr));
                wd_q.push_back(int'(bus.wdata));
                wc_q.push_back(c);
            end
            if (bus.done) begin
                done_cyc = c;
                break;
            end
            @(negedge clk);
        end
        check_eq("done_seen", 32'(done_cyc >= 0), 32'd1);
    endtask

    task automatic check_writes(input string tag);
        check_eq({tag, "_count"}, wa_q.size(), exp_a.size());
        for (int i = 0; i < exp_a.size() && i < wa_q.size(); i++) begin
            check_eq($sformatf("%s_addr%0d", tag, i), wa_q[i], exp_a[i]);
            check_eq($sformatf("%s_data%0d", tag, i), wd_q[i], exp_d[i]);
        end
    endtask

    task automatic wait_clear(input string tag);
        int cnt, err, seen;
        cnt = 0; err = 0; seen = 0;
        for (int c = 0; c < 20000; c++) begin
            if (bus.we) begin
                if (int'(bus.waddr) != cnt || bus.wdata != 6'd0) err++;
                cnt++;
            end
            if (bus.done) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        check_eq({tag, "_done"}, seen, 1);
        check_eq({tag, "_count"}, cnt, H * V);
        check_eq({tag, "_seq_err"}, err, 0);
        @(negedge clk);
        check_eq({tag, "_ready"}, bus.cmd_ready, 1);
        check_eq({tag, "_we_idle"}, bus.we, 0);
    endtask

    initial begin
        int viol, wr, p, a;
        bus.cmd_valid = 1'b0;
        bus.cmd_op = '0; bus.cmd_img = '0; bus.cmd_chr = '0; bus.cmd_x = '0; bus.cmd_y = '0;
        for (int i = 0; i < NI; i++)
            for (int j = 0; j < 128; j++) img_mem[i][j] = 6'd0;
        // image 0: zero-size (5 rows, width 0)
        img_mem[0][3] = 6'd5;
        // image 1: 3x2, pixels 1..6
        img_mem[1][1] = 6'd3; img_mem[1][3] = 6'd2;
        for (int k = 0; k < 6; k++) img_mem[1][4+k] = 6'(k + 1);
        // image 2: same with pixel 2 transparent
        img_mem[2][1] = 6'd3; img_mem[2][3] = 6'd2;
        for (int k = 0; k < 6; k++) img_mem[2][4+k] = 6'(k + 1);
        img_mem[2][5] = 6'h24;
        // image 3: 4x1, pixels 7..10
        img_mem[3][1] = 6'd4; img_mem[3][3] = 6'd1;
        for (int k = 0; k < 4; k++) img_mem[3][4+k] = 6'(k + 7);

        repeat (3) @(negedge clk);
        check_eq("rst_waddr", bus.waddr, 0);
        check_eq("rst_we", bus.we, 0);
        check_eq("rst_done", bus.done, 0);
        check_eq("rst_busy", bus.busy, 1);
        check_eq("rst_ready", bus.cmd_ready, 0);
        rst_n = 1'b1;
        wait_clear("clr0");

        run_cmd(0, 1, 0, 10, 5);
        exp_a = '{3210, 3211, 3212, 3850, 3851, 3852};
        exp_d = '{1, 2, 3, 4, 5, 6};
        check_writes("img1");
        if (wc_q.size() > 0) check_eq("img1_first_cyc", wc_q[0], 6);
        check_eq("img1_done_cyc", done_cyc, 11);

        run_cmd(0, 2, 0, 10, 5);
        exp_a = '{3210, 3212, 3850, 3851, 3852};
        exp_d = '{1, 3, 4, 5, 6};
        check_writes("img2");

        run_cmd(1, 2, 0, 10, 5);
        exp_d = '{0, 0, 0, 0, 0};
        check_writes("rm2");

        run_cmd(2, 0, 1, 0, 0);
        check_eq("gly_sel", rsel0, NI);
        check_eq("gly_ra0", ra_q.size() > 0 ? ra_q[0] : -1, 13);
        check_eq("gly_ra12", ra_q.size() > 12 ? ra_q[12] : -1, 25);
        check_eq("gly_ra13", ra_q.size() > 13 ? ra_q[13] : -1, 557);
        check_eq("gly_done_cyc", done_cyc, 209);
        exp_a.delete(); exp_d.delete();
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 13; c++) begin
                a = 13 + r * 544 + c;
                p = int'(font_pix(16'(a)));
                if (p != 'h24) begin
                    exp_a.push_back(r * H + c);
                    exp_d.push_back(p);
                end
            end
        check_writes("gly");

`ifdef PLACE_CLIP_EN
        exp_a = '{638, 639};
        exp_d = '{7, 8};
`else
        exp_a = '{638, 639, 640, 641};
        exp_d = '{7, 8, 9, 10};
`endif
        run_cmd(0, 3, 0, 638, 0);
        check_writes("edge");

        run_cmd(0, 0, 0, 100, 3);
        check_eq("zero_count", wa_q.size(), 0);
        check_eq("zero_done_cyc", done_cyc, 5);

        run_cmd(0, 4, 0, 10, 5);
        check_eq("badimg_count", wa_q.size(), 0);
        check_eq("badimg_done_cyc", done_cyc, 0);

        // image 0 becomes 64x1: width from the high header word
        img_mem[0][0] = 6'd1; img_mem[0][1] = 6'd0; img_mem[0][2] = 6'd0; img_mem[0][3] = 6'd1;
        for (int k = 0; k < 64; k++) img_mem[0][4+k] = 6'((k % 31) + 1);
        run_cmd(0, 0, 0, 0, 2);
        exp_a.delete(); exp_d.delete();
        for (int k = 0; k < 64; k++) begin
            exp_a.push_back(1280 + k);
            exp_d.push_back((k % 31) + 1);
        end
        check_writes("wide");
        check_eq("wide_done_cyc", done_cyc, 69);

        // command held valid through busy
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_op = 2'd0; bus.cmd_img = 3'd1; bus.cmd_x = 10'd10; bus.cmd_y = 9'd5;
        viol = 0; wr = 0; p = 0;
        for (int c = 0; c < 200; c++) begin
            if (bus.busy && bus.cmd_ready) viol++;
            if (bus.we) wr++;
            if (bus.done) begin
                bus.cmd_valid = 1'b0;
                p = 1;
                break;
            end
            @(negedge clk);
        end
        check_eq("hold_done", p, 1);
        check_eq("hold_viol", viol, 0);
        check_eq("hold_writes", wr, 6);
        repeat (2) @(negedge clk);
        check_eq("hold_idle", bus.cmd_ready, 1);

        run_cmd(3, 0, 0, 0, 0);
        check_eq("clrcmd_count", wa_q.size(), H * V);
        check_eq("clrcmd_first", wa_q.size() > 0 ? wa_q[0] : -1, 0);
        check_eq("clrcmd_last", wa_q.size() > 0 ? wa_q[wa_q.size()-1] : -1, H * V - 1);

        // reset in the middle of a 64-pixel write run
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_op = 2'd0; bus.cmd_img = 3'd0; bus.cmd_x = 10'd0; bus.cmd_y = 9'd2;
        p = 0;
        while (!bus.cmd_ready && p < 50) begin
            @(negedge clk);
            p++;
        end
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        repeat (20) @(negedge clk);
        check_eq("midwrt_we", bus.we, 1);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_waddr", bus.waddr, 0);
        check_eq("midrst_we", bus.we, 0);
        check_eq("midrst_busy", bus.busy, 1);
        check_eq("midrst_ready", bus.cmd_ready, 0);
        check_eq("midrst_done", bus.done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_clear("clr1");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/place_bmp_param.md
PLACE_BMP_PARAM -- requirements
Module: place_bmp_param

Interface
Parameters (name, default, meaning):
REQ-001 H_RES, 640, screen width in pixels.
REQ-002 V_RES, 480, screen height in pixels.
REQ-003 PIX_W, 6, bits per pixel.
REQ-004 N_IMG, 4, number of image ROMs; ROM select value N_IMG addresses the font ROM.
REQ-005 TRANSP, 6'h24, transparent pixel code.
REQ-006 GLYPH_W / GLYPH_H / FONT_STRIDE, 13 / 16 / 544, glyph size and font ROM row stride.

Ports (name, direction, width, meaning):
REQ-007 clk, in, 1, clock.
REQ-008 rst_n, in, 1, reset; asynchronous, active-low.
REQ-009 cmd_valid, in, 1, command offered.
REQ-010 cmd_ready, out, 1, command accepted when high with cmd_valid.
REQ-011 cmd_op, in, 2, operation: 0 add image, 1 remove image, 2 add glyph, 3 clear screen.
REQ-012 cmd_img, in, clog2(N_IMG+1), image index.
REQ-013 cmd_chr, in, 6, glyph index 0..41.
REQ-014 cmd_x, in, 10, left x; cmd_y, in, 9, top y.
REQ-015 rom_sel, out, clog2(N_IMG+1), ROM select; rom_addr, out, 16, ROM address.
REQ-016 rom_data, in, PIX_W, ROM data; 1-cycle read latency.
REQ-017 waddr, out, 19, linear video address y*H_RES+x; wdata, out, PIX_W; we, out, 1.
REQ-018 busy, out, 1; done, out, 1, single-cycle pulse at command completion.

Function
REQ-019 cmd_ready SHALL equal (state==IDLE); the command is captured on the cycle of the handshake.
REQ-020 States SHALL be CLR, IDLE, HDR, WRT, GLY, FIN; busy is high in every state except IDLE.
REQ-021 CLR SHALL write 0 to every address 0..H_RES*V_RES-1, one per cycle, then go to FIN.
REQ-022 Image ROM layout: addr 0..3 = xhi, xlo, yhi, ylo with width = hi*64+lo; pixels row-major from addr 4.
REQ-023 HDR SHALL read the 4 header words; the first pixel write occurs 6 cycles after the handshake.
REQ-024 WRT SHALL emit one pixel per cycle, stepping x then y, and SHALL go to FIN after pixel (w-1,h-1).
REQ-025 Pixels equal to TRANSP SHALL give we=0; otherwise we=1.
REQ-026 For remove, wdata SHALL be 0 while transparency gating is unchanged.
REQ-027 GLY SHALL read font address chr*GLYPH_W + row*FONT_STRIDE + col and write GLYPH_W x GLYPH_H pixels with TRANSP gating, then go to FIN.
REQ-028 An image of width or height 0 SHALL perform no writes and SHALL reach FIN.
REQ-029 cmd_img >= N_IMG with op 0 or 1 SHALL perform no writes and SHALL pulse done.
REQ-030 FIN SHALL pulse done for one cycle and return to IDLE.
REQ-031 Address arithmetic SHALL be 19-bit unsigned with no truncation for coordinates below H_RES x V_RES.

Reset
REQ-032 Reset SHALL force state CLR, with waddr=0, we=0, done=0, busy=1 and cmd_ready=0.
REQ-033 Reset asserted mid-command SHALL abort the command, and the screen SHALL be re-cleared after release.

Configuration
REQ-034 With PLACE_CLIP_EN defined, any pixel with x>=H_RES or y>=V_RES SHALL have we=0 while ROM stepping continues.
REQ-035 Without PLACE_CLIP_EN, off-screen pixels SHALL wrap linearly, with waddr continuing at +1 modulo 2^19.

Verification
REQ-036 Reset release -> 307200 writes of 0 with we=1, done pulse, then cmd_ready=1.
REQ-037 Add image 1 (3x2, pixels 1..6) at (10,5) -> writes 1..6 at 3210..3212 and 3850..3852, then done.
REQ-038 Same image with pixel 2 = 6'h24 -> no write at 3211; remove command -> 0 written at the five other addresses.
REQ-039 Glyph chr=1 at (0,0) -> 208 font reads starting at address 13, row stride 544, writes at rows 0..15, columns 0..12.
REQ-040 Image 4x1 at (638,0) -> PLACE_CLIP_EN: writes only at 638 and 639; without it: writes at 638..641.
REQ-041 cmd_valid held high during busy -> no capture until IDLE; rst_n pulse mid-WRT -> CLR restarts and waddr=0.
